// File: rtl/uart.sv
// uart: full-duplex 8N1 UART with baud-rate generator
// and a small FIFO in each direction.

// Circular-buffer FIFO with show-ahead head data.
module uart_fifo #(
   parameter int DW = 8,
   parameter int AW = 2
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          rd,
   input  logic          wr,
   input  logic [DW-1:0] w_data,
   output logic          empty,
   output logic          full,
   output logic [DW-1:0] r_data
);

   logic [DW-1:0] mem [2**AW];
   logic [AW-1:0] w_ptr;
   logic [AW-1:0] w_ptr_n;
   logic [AW-1:0] r_ptr;
   logic [AW-1:0] r_ptr_n;
   logic [AW-1:0] w_succ;
   logic [AW-1:0] r_succ;
   logic          full_n;
   logic          empty_n;
   logic          wr_en;

   assign wr_en  = wr & ~full;
   assign r_data = mem[r_ptr];
   assign w_succ = w_ptr + AW'(1);
   assign r_succ = r_ptr + AW'(1);

   // Storage write; contents need no reset.
   always_ff @(posedge clk) begin
      if (wr_en)
         mem[w_ptr] <= w_data;
   end

   // Pointer and flag registers.
   always_ff @(posedge clk) begin
      if (reset) begin
         w_ptr <= '0;
         r_ptr <= '0;
         full  <= 1'b0;
         empty <= 1'b1;
      end else begin
         w_ptr <= w_ptr_n;
         r_ptr <= r_ptr_n;
         full  <= full_n;
         empty <= empty_n;
      end
   end

   // Next pointers; a blocked side of a dual access is dropped.
   always_comb begin
      w_ptr_n = w_ptr;
      r_ptr_n = r_ptr;
      full_n  = full;
      empty_n = empty;
      unique case ({wr, rd})
         2'b01: begin
            if (!empty) begin
               r_ptr_n = r_succ;
               full_n  = 1'b0;
               empty_n = (r_succ == w_ptr);
            end
         end
         2'b10: begin
            if (!full) begin
               w_ptr_n = w_succ;
               empty_n = 1'b0;
               full_n  = (w_succ == r_ptr);
            end
         end
         2'b11: begin
            if (empty) begin
               w_ptr_n = w_succ;
               empty_n = 1'b0;
               full_n  = (w_succ == r_ptr);
            end else if (full) begin
               r_ptr_n = r_succ;
               full_n  = 1'b0;
               empty_n = (r_succ == w_ptr);
            end else begin
               w_ptr_n = w_succ;
               r_ptr_n = r_succ;
            end
         end
         default: begin
         end
      endcase
   end

endmodule

// Serial transmitter: start, DBIT data bits LSB first, stop.
module uart_tx #(
   parameter int DBIT    = 8,
   parameter int SB_TICK = 16
) (
   input  logic            clk,
   input  logic            reset,
   input  logic            tx_start,
   input  logic            s_tick,
   input  logic [DBIT-1:0] din,
   output logic            tx_done_tick,
   output logic            tx
);

   localparam int SW = (SB_TICK > 16) ? $clog2(SB_TICK) : 4;
   localparam int NW = (DBIT > 1) ? $clog2(DBIT) : 1;

   typedef enum logic [1:0] {
      idle,
      start,
      data,
      stop
   } state_t;

   state_t          state;
   state_t          state_n;
   logic [SW-1:0]   s_cnt;
   logic [SW-1:0]   s_cnt_n;
   logic [NW-1:0]   n_cnt;
   logic [NW-1:0]   n_cnt_n;
   logic [DBIT-1:0] b_reg;
   logic [DBIT-1:0] b_reg_n;
   logic            tx_reg;
   logic            tx_n;

   assign tx = tx_reg;

   // State and datapath registers; tx idles high.
   always_ff @(posedge clk) begin
      if (reset) begin
         state  <= idle;
         s_cnt  <= '0;
         n_cnt  <= '0;
         b_reg  <= '0;
         tx_reg <= 1'b1;
      end else begin
         state  <= state_n;
         s_cnt  <= s_cnt_n;
         n_cnt  <= n_cnt_n;
         b_reg  <= b_reg_n;
         tx_reg <= tx_n;
      end
   end

   // Next-state logic; each bit lasts 16 ticks.
   always_comb begin
      state_n      = state;
      s_cnt_n      = s_cnt;
      n_cnt_n      = n_cnt;
      b_reg_n      = b_reg;
      tx_n         = tx_reg;
      tx_done_tick = 1'b0;
      unique case (state)
         idle: begin
            tx_n = 1'b1;
            if (tx_start) begin
               state_n = start;
               s_cnt_n = '0;
               b_reg_n = din;
            end
         end
         start: begin
            tx_n = 1'b0;
            if (s_tick) begin
               if (s_cnt == SW'(15)) begin
                  state_n = data;
                  s_cnt_n = '0;
                  n_cnt_n = '0;
               end else begin
                  s_cnt_n = s_cnt + SW'(1);
               end
            end
         end
         data: begin
            tx_n = b_reg[0];
            if (s_tick) begin
               if (s_cnt == SW'(15)) begin
                  s_cnt_n = '0;
                  b_reg_n = b_reg >> 1;
                  if (n_cnt == NW'(DBIT - 1))
                     state_n = stop;
                  else
                     n_cnt_n = n_cnt + NW'(1);
               end else begin
                  s_cnt_n = s_cnt + SW'(1);
               end
            end
         end
         stop: begin
            tx_n = 1'b1;
            if (s_tick) begin
               if (s_cnt == SW'(SB_TICK - 1)) begin
                  state_n      = idle;
                  tx_done_tick = 1'b1;
               end else begin
                  s_cnt_n = s_cnt + SW'(1);
               end
            end
         end
         default: state_n = idle;
      endcase
   end

endmodule

// Serial receiver: samples mid-bit using 16x oversampling.
module uart_rx #(
   parameter int DBIT    = 8,
   parameter int SB_TICK = 16
) (
   input  logic            clk,
   input  logic            reset,
   input  logic            rx,
   input  logic            s_tick,
   output logic            rx_done_tick,
   output logic [DBIT-1:0] dout
);

   localparam int SW = (SB_TICK > 16) ? $clog2(SB_TICK) : 4;
   localparam int NW = (DBIT > 1) ? $clog2(DBIT) : 1;

   typedef enum logic [1:0] {
      idle,
      start,
      data,
      stop
   } state_t;

   state_t          state;
   state_t          state_n;
   logic [SW-1:0]   s_cnt;
   logic [SW-1:0]   s_cnt_n;
   logic [NW-1:0]   n_cnt;
   logic [NW-1:0]   n_cnt_n;
   logic [DBIT-1:0] b_reg;
   logic [DBIT-1:0] b_reg_n;

   assign dout = b_reg;

   // State and shift registers.
   always_ff @(posedge clk) begin
      if (reset) begin
         state <= idle;
         s_cnt <= '0;
         n_cnt <= '0;
         b_reg <= '0;
      end else begin
         state <= state_n;
         s_cnt <= s_cnt_n;
         n_cnt <= n_cnt_n;
         b_reg <= b_reg_n;
      end
   end

   // Next-state logic; stop bit value is not checked.
   always_comb begin
      state_n      = state;
      s_cnt_n      = s_cnt;
      n_cnt_n      = n_cnt;
      b_reg_n      = b_reg;
      rx_done_tick = 1'b0;
      unique case (state)
         idle: begin
            if (!rx) begin
               state_n = start;
               s_cnt_n = '0;
            end
         end
         start: begin
            if (s_tick) begin
               if (s_cnt == SW'(7)) begin
                  state_n = data;
                  s_cnt_n = '0;
                  n_cnt_n = '0;
               end else begin
                  s_cnt_n = s_cnt + SW'(1);
               end
            end
         end
         data: begin
            if (s_tick) begin
               if (s_cnt == SW'(15)) begin
                  s_cnt_n = '0;
                  b_reg_n = {rx, b_reg[DBIT-1:1]};
                  if (n_cnt == NW'(DBIT - 1))
                     state_n = stop;
                  else
                     n_cnt_n = n_cnt + NW'(1);
               end else begin
                  s_cnt_n = s_cnt + SW'(1);
               end
            end
         end
         stop: begin
            if (s_tick) begin
               if (s_cnt == SW'(SB_TICK - 1)) begin
                  state_n      = idle;
                  rx_done_tick = 1'b1;
               end else begin
                  s_cnt_n = s_cnt + SW'(1);
               end
            end
         end
         default: state_n = idle;
      endcase
   end

endmodule

// Top: baud generator, tx/rx engines and their FIFOs.
module uart #(
   parameter int DBIT    = 8,
   parameter int SB_TICK = 16,
   parameter int FIFO_W  = 2
) (
   input  logic            clk,
   input  logic            reset,
   input  logic            rd_uart,
   input  logic            wr_uart,
   input  logic            rx,
   input  logic [DBIT-1:0] w_data,
   input  logic [10:0]     dvsr,
   output logic            tx_full,
   output logic            rx_empty,
   output logic            tx,
   output logic [DBIT-1:0] r_data
);

   logic [10:0]     cnt;
   logic            s_tick;
   logic            tx_done_tick;
   logic            rx_done_tick;
   logic            tx_empty;
   logic [DBIT-1:0] tx_head;
   logic [DBIT-1:0] rx_byte;

   assign s_tick = (cnt == 11'd1);

   // Baud counter wraps after dvsr, one tick per dvsr+1 clocks.
   always_ff @(posedge clk) begin
      if (reset)
         cnt <= '0;
      else if (cnt == dvsr)
         cnt <= '0;
      else
         cnt <= cnt + 11'd1;
   end

   uart_rx #(
      .DBIT    (DBIT),
      .SB_TICK (SB_TICK)
   ) u_rx (
      .clk          (clk),
      .reset        (reset),
      .rx           (rx),
      .s_tick       (s_tick),
      .rx_done_tick (rx_done_tick),
      .dout         (rx_byte)
   );

   uart_fifo #(
      .DW (DBIT),
      .AW (FIFO_W)
   ) u_rx_fifo (
      .clk    (clk),
      .reset  (reset),
      .rd     (rd_uart),
      .wr     (rx_done_tick),
      .w_data (rx_byte),
      .empty  (rx_empty),
      .full   (),
      .r_data (r_data)
   );

   uart_fifo #(
      .DW (DBIT),
      .AW (FIFO_W)
   ) u_tx_fifo (
      .clk    (clk),
      .reset  (reset),
      .rd     (tx_done_tick),
      .wr     (wr_uart),
      .w_data (w_data),
      .empty  (tx_empty),
      .full   (tx_full),
      .r_data (tx_head)
   );

   uart_tx #(
      .DBIT    (DBIT),
      .SB_TICK (SB_TICK)
   ) u_tx (
      .clk          (clk),
      .reset        (reset),
      .tx_start     (~tx_empty),
      .s_tick       (s_tick),
      .din          (tx_head),
      .tx_done_tick (tx_done_tick),
      .tx           (tx)
   );

endmodule

// File: tb/tb_uart.sv
// tb_uart: random/directed bench for the uart, with a
// serial-line decoder and queue-based FIFO models.
module tb_uart;

   logic        clk = 1'b0;
   logic        reset;
   logic        rd_uart;
   logic        wr_uart;
   logic        rx;
   logic [7:0]  w_data;
   logic [10:0] dvsr;
   logic        tx_full;
   logic        rx_empty;
   logic        tx;
   logic [7:0]  r_data;

   int vecs = 0;
   int errs = 0;
   int tk;
   int bt;
   int cyc = 0;
   int frames_seen = 0;
   bit mon_go = 1'b0;
   logic [7:0] mdl_tx [$];
   logic [7:0] mdl_rx [$];

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   uart dut (
      .clk      (clk),
      .reset    (reset),
      .rd_uart  (rd_uart),
      .wr_uart  (wr_uart),
      .rx       (rx),
      .w_data   (w_data),
      .dvsr     (dvsr),
      .tx_full  (tx_full),
      .rx_empty (rx_empty),
      .tx       (tx),
      .r_data   (r_data)
   );

   task automatic chk(input string tag, input logic [31:0] got,
                      input logic [31:0] exp);
      vecs++;
      if (got !== exp) begin
         errs++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic mon_wait(input int n, output bit ab);
      ab = 1'b0;
      repeat (n) begin
         @(negedge clk);
         if (reset) ab = 1'b1;
      end
   endtask

   // Line decoder: samples each bit near its middle.
   initial begin : tx_mon
      logic       prev;
      logic [7:0] d;
      bit         ab;
      wait (mon_go);
      prev = 1'b1;
      forever begin
         @(negedge clk);
         if (!reset && prev && !tx) begin
            mon_wait(8 * tk, ab);
            if (!ab) begin
               chk("tx_start_bit", tx, 1'b0);
               for (int i = 0; i < 8 && !ab; i++) begin
                  mon_wait(bt, ab);
                  d[i] = tx;
               end
               if (!ab) mon_wait(bt, ab);
               if (!ab) begin
                  chk("tx_stop_bit", tx, 1'b1);
                  if (mdl_tx.size() == 0)
                     chk("tx_unexpected", 1, 0);
                  else
                     chk("tx_byte", d, mdl_tx.pop_front());
                  frames_seen++;
               end
            end
         end
         prev = tx;
      end
   end

   task automatic wr_byte(input logic [7:0] b);
      bit acc;
      acc = (mdl_tx.size() < 4);
      w_data  = b;
      wr_uart = 1'b1;
      @(negedge clk);
      wr_uart = 1'b0;
      if (acc) mdl_tx.push_back(b);
      @(negedge clk);
   endtask

   task automatic wait_tx(input logic v, input int max, output int n);
      n = 0;
      while (tx !== v && n < max) begin
         @(negedge clk);
         n++;
      end
      if (n >= max) chk("tx_wait_timeout", 0, 1);
   endtask

   task automatic drain_tx();
      int n;
      n = 0;
      while (mdl_tx.size() != 0 && n < 50 * bt) begin
         @(negedge clk);
         n++;
      end
      chk("tx_drain", mdl_tx.size(), 0);
      repeat (bt) @(negedge clk);
      chk("tx_idle", tx, 1'b1);
      chk("tx_full_idle", tx_full, 1'b0);
   endtask

   task automatic chk_rx_head();
      chk("rx_empty", rx_empty, mdl_rx.size() == 0);
      if (mdl_rx.size() != 0) chk("r_data", r_data, mdl_rx[0]);
   endtask

   task automatic rx_frame(input logic [7:0] b);
      rx = 1'b0;
      repeat (bt) @(negedge clk);
      for (int i = 0; i < 8; i++) begin
         rx = b[i];
         repeat (bt) @(negedge clk);
      end
      rx = 1'b1;
      repeat (2 * bt) @(negedge clk);
      if (mdl_rx.size() < 4) mdl_rx.push_back(b);
      chk_rx_head();
   endtask

   task automatic rd_pulse();
      rd_uart = 1'b1;
      @(negedge clk);
      rd_uart = 1'b0;
      if (mdl_rx.size() != 0) void'(mdl_rx.pop_front());
      chk_rx_head();
   endtask

   initial begin : watchdog
      repeat (95000) @(posedge clk);
      $display("FAIL watchdog: cycle budget exhausted");
      $fatal(1, "timeout");
   end

   initial begin : main
      int n;
      int t0;
      int base;
      logic [7:0] burst [5];
      reset   = 1'b1;
      rd_uart = 1'b0;
      wr_uart = 1'b0;
      rx      = 1'b1;
      w_data  = '0;
      dvsr    = 11'($urandom_range(3, 9));
      tk      = int'(dvsr) + 1;
      bt      = 16 * tk;
      repeat (4) @(negedge clk);
      chk("rst_tx", tx, 1'b1);
      chk("rst_tx_full", tx_full, 1'b0);
      chk("rst_rx_empty", rx_empty, 1'b1);
      reset = 1'b0;
      @(negedge clk);
      mon_go = 1'b1;

      wr_byte(8'h55);
      chk("tx_full_one", tx_full, 1'b0);
      wait_tx(1'b0, 2 * bt, n);
      wait_tx(1'b1, 2 * bt, n);
      wait_tx(1'b0, 2 * bt, n);
      chk("bit_time", n, bt);
      drain_tx();

      wr_byte(8'hAA);
      drain_tx();

      burst = '{8'hF0, 8'h0F, 8'h00, 8'hFF, 8'h00};
      t0   = cyc;
      base = frames_seen;
      for (int i = 0; i < 5; i++) begin
         wr_byte(burst[i]);
         chk("burst_full", tx_full, mdl_tx.size() == 4);
      end
      while (cyc - t0 < (37 * bt) / 4) @(negedge clk);
      chk("full_hold", tx_full, 1'b1);
      while (cyc - t0 < (41 * bt) / 4) @(negedge clk);
      chk("full_clear", tx_full, 1'b0);
      n = 0;
      while (frames_seen < base + 4 && n < 45 * bt) begin
         @(negedge clk);
         n++;
      end
      chk("burst_frames", frames_seen - base, 4);
      chk("burst_b2b", (cyc - t0 >= 39 * bt) && (cyc - t0 <= 40 * bt), 1);
      drain_tx();
      repeat (2 * bt) @(negedge clk);
      chk("burst_dropped", frames_seen - base, 4);

      rx_frame(8'h55);
      rx_frame(8'hAA);
      rx_frame(8'h00);
      repeat (4) rd_pulse();

      for (int i = 0; i < 5; i++) rx_frame(8'($urandom));
      repeat (5) rd_pulse();

      fork
         begin
            for (int i = 0; i < 3; i++) wr_byte(8'($urandom));
         end
         begin
            for (int i = 0; i < 3; i++) rx_frame(8'($urandom));
         end
      join
      repeat (3) rd_pulse();
      drain_tx();

      wr_byte(8'($urandom));
      wr_byte(8'($urandom));
      rx = 1'b0;
      repeat (3 * bt) @(negedge clk);
      rx    = 1'b1;
      reset = 1'b1;
      @(negedge clk);
      chk("mid_rst_tx", tx, 1'b1);
      chk("mid_rst_rx_empty", rx_empty, 1'b1);
      chk("mid_rst_tx_full", tx_full, 1'b0);
      mdl_tx.delete();
      mdl_rx.delete();
      @(negedge clk);
      reset = 1'b0;
      repeat (2 * bt) @(negedge clk);
      wr_byte(8'($urandom));
      rx_frame(8'($urandom));
      rd_pulse();
      drain_tx();

      $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
      $finish;
   end

endmodule
